// File: rtl/mem_access.sv
// Memory-access pipeline stage: forwards ALU results to writeback, or runs a
// single load/store bus transaction with alignment checking and load lane extraction.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_pc,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_we,
  input  logic [4:0]  mem_write_reg,
  input  logic [31:0] mem_write_data,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] wb_pc,
  output logic        wb_we,
  output logic [4:0]  wb_write_reg,
  output logic [31:0] wb_write_data,
  output logic        stall_req,
  output logic        misalign,
  output logic [31:0] bad_addr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8;

  logic [0:0]  state;
  logic [31:0] pc_q;
  logic [3:0]  op_q;
  logic        we_q;
  logic [4:0]  reg_q;
  logic [1:0]  lo_q;

  logic        is_load, is_store, is_mem, mis, load_q;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    is_load  = (mem_op >= OP_LB) && (mem_op <= OP_LW);
    is_store = (mem_op >= OP_SB) && (mem_op <= OP_SW);
    is_mem   = is_load || is_store;
    mis      = 1'b0;
    if (mem_op == OP_LH || mem_op == OP_LHU || mem_op == OP_SH) mis = mem_addr[0];
    if (mem_op == OP_LW || mem_op == OP_SW)                     mis = |mem_addr[1:0];
  end

  // Loads always fetch the whole word; lane selection happens on return.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = mem_data;
    case (mem_op)
      OP_SB: begin
        st_be    = 4'b0001 << mem_addr[1:0];
        st_wdata = {4{mem_data[7:0]}};
      end
      OP_SH: begin
        st_be    = 4'b0011 << mem_addr[1:0];
        st_wdata = {2{mem_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_q  = (op_q >= OP_LB) && (op_q <= OP_LW);
    ld_byte = bus_rdata[{lo_q, 3'b000} +: 8];
    ld_half = bus_rdata[{lo_q[1], 4'b0000} +: 16];
    case (op_q)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'd0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = bus_rdata;
    endcase
  end

  assign stall_req = !rst && (((state == IDLE) && is_mem && !mis) ||
                              ((state == WAIT) && !bus_ack));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus_req       <= 1'b0;
      bus_wr        <= 1'b0;
      bus_addr      <= '0;
      bus_be        <= '0;
      bus_wdata     <= '0;
      wb_pc         <= '0;
      wb_we         <= 1'b0;
      wb_write_reg  <= '0;
      wb_write_data <= '0;
      misalign      <= 1'b0;
      bad_addr      <= '0;
      pc_q          <= '0;
      op_q          <= '0;
      we_q          <= 1'b0;
      reg_q         <= '0;
      lo_q          <= '0;
    end else begin
      wb_we    <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (is_mem && !mis) begin
            state     <= WAIT;
            bus_req   <= 1'b1;
            bus_wr    <= is_store;
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_be    <= st_be;
            bus_wdata <= st_wdata;
            pc_q      <= mem_pc;
            op_q      <= mem_op;
            we_q      <= mem_we;
            reg_q     <= mem_write_reg;
            lo_q      <= mem_addr[1:0];
          end else if (is_mem) begin
            misalign <= 1'b1;
            bad_addr <= mem_addr;
          end else begin
            wb_pc         <= mem_pc;
            wb_we         <= mem_we;
            wb_write_reg  <= mem_write_reg;
            wb_write_data <= mem_write_data;
          end
        end
        default: begin
          // Bus outputs stay frozen until the ack is sampled.
          if (bus_ack) begin
            state        <= IDLE;
            bus_req      <= 1'b0;
            bus_wr       <= 1'b0;
            wb_pc        <= pc_q;
            wb_we        <= we_q && load_q;
            wb_write_reg <= reg_q;
            if (load_q) wb_write_data <= ld_data;
          end
        end
      endcase
    end
  end

endmodule
